uart_packet_parser: RTL and testbench
=====================================

UART_PACKET_PARSER -- requirements
Module: uart_packet_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, meaning the maximum payload bytes per packet (range 1..255).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hAA, meaning the packet start marker.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4350, meaning the maximum idle clk cycles allowed between bytes inside a packet (about 10 bit-times at 435 clk/bit).
REQ-004 clk  input  1  sole clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 in_data  input  8  received byte from the UART receiver; meaningful only when in_valid=1.
REQ-007 in_valid  input  1  single-cycle pulse marking one received byte; no backpressure exists upstream.
REQ-008 out_data  output  8  payload byte being presented downstream.
REQ-009 out_valid  output  1  out_data holds a valid payload byte.
REQ-010 out_ready  input  1  downstream accepts the byte; a transfer occurs when out_valid=1 and out_ready=1.
REQ-011 out_last  output  1  qualifies the final payload byte of a packet; valid only with out_valid.
REQ-012 pkt_err  output  1  one-cycle pulse on any framing, length, checksum or timeout error.
REQ-013 pkt_drop  output  1  one-cycle pulse for each input byte discarded while in SEND.

Function
REQ-014 Frame format SHALL be: SYNC_BYTE, LEN, LEN payload bytes, CHK, where CHK = (LEN + sum of payload bytes) mod 256.
REQ-015 States SHALL be HUNT, LEN, PAYLOAD, CHECK and SEND; only bytes with in_valid=1 advance the state.
REQ-016 HUNT: a byte equal to SYNC_BYTE moves to LEN; all other bytes are ignored silently with no pkt_err.
REQ-017 LEN: byte L with L=0 or L>MAX_LEN pulses pkt_err and returns to HUNT.
REQ-018 LEN: any other L latches the length, sets sum=L and write index=0, and moves to PAYLOAD.
REQ-019 PAYLOAD: each byte is written to buf[index], sum += byte (8-bit wrap) and index increments; writing byte LEN-1 moves to CHECK.
REQ-020 PAYLOAD: a SYNC_BYTE value inside the payload is treated as data.
REQ-021 CHECK: a byte equal to sum moves to SEND with read index=0; a mismatch pulses pkt_err and returns to HUNT with no output.
REQ-022 Timeout: in LEN, PAYLOAD and CHECK a cycle counter clears on every in_valid.
REQ-023 Timeout: when the counter reaches TIMEOUT_CYCLES-1 without in_valid, the block pulses pkt_err, returns to HUNT and clears the counter.
REQ-024 Timeout: the counter is held at 0 in HUNT and SEND.
REQ-025 SEND: out_valid=1, out_data=buf[read index], out_last=1 when read index=LEN-1.
REQ-026 SEND: each transfer advances the read index; the transfer of the last byte returns to HUNT and deasserts out_valid on the next cycle.
REQ-027 SEND: while out_valid=1 and out_ready=0, out_data and out_last SHALL be held stable.
REQ-028 SEND: every in_valid byte arriving in SEND is discarded and pulses pkt_drop in the following cycle; it is not parsed, even if it equals SYNC_BYTE.
REQ-029 First output latency: out_valid SHALL rise in the cycle after the clk edge that samples a correct CHK.
REQ-030 pkt_err and pkt_drop SHALL be registered and assert for exactly one cycle per event.
REQ-031 out_valid SHALL be 0 in every state except SEND.

Reset
REQ-032 While rst_n=0: state=HUNT and out_valid, out_last, pkt_err, pkt_drop, out_data, all indices, sum and timeout counter = 0.
REQ-033 Payload buffer contents are not reset.
REQ-034 Reset asserted mid-packet or mid-SEND SHALL abandon the packet immediately, with no pkt_err.
REQ-035 The first SYNC_BYTE after rst_n deasserts SHALL start a new packet.

Verification
REQ-036 Good packet: AA 03 11 22 33 69 -> out bytes 11, 22, 33 with out_ready=1; out_last only on 33; pkt_err never asserts.
REQ-037 Bad checksum and garbage: 55 00 AA 02 10 20 00 -> one pkt_err pulse and no out_valid; then AA 01 5A 5B -> outputs 5A with out_last=1.
REQ-038 Length limits: AA 00 -> pkt_err; AA 11 (17 > MAX_LEN) -> pkt_err; AA 10 with 16 bytes and correct CHK -> 16 outputs.
REQ-039 Checksum wrap and backpressure: AA 02 FF FF 00 -> accepted; holding out_ready=0 for 5 cycles keeps out_data=FF and out_valid=1 stable; a byte injected during SEND -> one pkt_drop pulse.
REQ-040 Timeout: AA 02 10 then 4350 idle cycles -> pkt_err exactly TIMEOUT_CYCLES cycles after the byte 10; a following AA 01 7E 7F -> outputs 7E.
REQ-041 Reset mid-SEND: rst_n low for 2 cycles during out_valid -> out_valid=0 immediately, no pkt_err; the next good packet parses correctly.

Source files
------------

// File: rtl/uart_packet_parser_if.sv
// Byte stream in from the UART receiver, payload stream out, plus error/drop pulses.
interface uart_packet_parser_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       pkt_err;
    logic       pkt_drop;

    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid, out_last, pkt_err, pkt_drop
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid, out_last, pkt_err, pkt_drop
    );
endinterface

// File: rtl/uart_packet_parser.sv
// Parses SYNC/LEN/payload/CHK frames from a UART byte stream, buffers the payload
// and replays it downstream with valid/ready once the checksum matches.
module uart_packet_parser #(
    parameter int unsigned MAX_LEN        = 16,
    parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
    parameter int unsigned TIMEOUT_CYCLES = 4350
) (
    input logic                  clk,
    input logic                  rst_n,
    uart_packet_parser_if.slave  bus
);

    localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHECK,
        ST_SEND
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         sum_q, sum_d;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [7:0]         out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               pkt_err_q, pkt_err_d;
    logic               pkt_drop_q, pkt_drop_d;

    logic [7:0]         pay_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HUNT;
            len_q       <= '0;
            sum_q       <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            tmo_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            pkt_err_q   <= 1'b0;
            pkt_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            tmo_q       <= tmo_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            pkt_err_q   <= pkt_err_d;
            pkt_drop_q  <= pkt_drop_d;
        end
    end

    // Payload storage is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (state_q == ST_PAYLOAD && bus.in_valid) begin
            pay_mem[wr_idx_q] <= bus.in_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        sum_d       = sum_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        tmo_d       = '0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        pkt_err_d   = 1'b0;
        pkt_drop_d  = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (bus.in_valid && bus.in_data == SYNC_BYTE) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (bus.in_valid) begin
                    if (bus.in_data == 8'd0 || bus.in_data > 8'(MAX_LEN)) begin
                        pkt_err_d = 1'b1;
                        state_d   = ST_HUNT;
                    end else begin
                        len_d    = bus.in_data;
                        sum_d    = bus.in_data;
                        wr_idx_d = '0;
                        state_d  = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (bus.in_valid) begin
                    sum_d    = sum_q + bus.in_data;
                    wr_idx_d = wr_idx_q + IDX_W'(1);
                    if (8'(wr_idx_q) == len_q - 8'd1) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (bus.in_valid) begin
                    if (bus.in_data == sum_q) begin
                        state_d     = ST_SEND;
                        rd_idx_d    = '0;
                        out_valid_d = 1'b1;
                        out_data_d  = pay_mem[IDX_W'(0)];
                        out_last_d  = (len_q == 8'd1);
                    end else begin
                        pkt_err_d = 1'b1;
                        state_d   = ST_HUNT;
                    end
                end
            end
            ST_SEND: begin
                // Upstream cannot be stalled, so bytes arriving now are lost.
                if (bus.in_valid) begin
                    pkt_drop_d = 1'b1;
                end
                if (out_valid_q && bus.out_ready) begin
                    if (out_last_q) begin
                        state_d     = ST_HUNT;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        rd_idx_d   = rd_idx_q + IDX_W'(1);
                        out_data_d = pay_mem[rd_idx_d];
                        out_last_d = (8'(rd_idx_d) == len_q - 8'd1);
                    end
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        // Inter-byte timeout; the counter stays cleared whenever a byte arrives.
        if ((state_q == ST_LEN || state_q == ST_PAYLOAD || state_q == ST_CHECK)
            && !bus.in_valid) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                pkt_err_d = 1'b1;
                state_d   = ST_HUNT;
                tmo_d     = '0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.pkt_err   = pkt_err_q;
    assign bus.pkt_drop  = pkt_drop_q;

endmodule

// File: tb/tb_uart_packet_parser.sv
// Directed bench for uart_packet_parser with hand-computed frames and expected outputs.
module tb_uart_packet_parser;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_packet_parser_if bus ();

    uart_packet_parser dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int err_cnt;
    int drop_cnt;
    int vld_cnt;
    logic [8:0] outq [$];
    logic [7:0] seq  [$];

    // Observe outputs mid-cycle; a transfer is recorded when valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) outq.push_back({bus.out_last, bus.out_data});
            if (bus.pkt_err)  err_cnt++;
            if (bus.pkt_drop) drop_cnt++;
            if (bus.out_valid) vld_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_seq();
        foreach (seq[i]) send_byte(seq[i]);
    endtask

    task automatic clr_mon();
        outq.delete();
        err_cnt  = 0;
        drop_cnt = 0;
        vld_cnt  = 0;
    endtask

    function automatic logic [8:0] outq_at(input int i);
        if (i < outq.size()) return outq[i];
        return 'x;
    endfunction

    int n;

    initial begin
        rst_n        = 1'b0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        clr_mon();
        repeat (3) tick();

        // Reset values
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_last",  32'(bus.out_last),  32'd0);
        check("rst_pkt_err",   32'(bus.pkt_err),   32'd0);
        check("rst_pkt_drop",  32'(bus.pkt_drop),  32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Good packet
        clr_mon();
        seq = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send_seq();
        check("good_latency", 32'(bus.out_valid), 32'd1);
        repeat (10) tick();
        check("good_count", 32'(outq.size()), 32'd3);
        check("good_b0", 32'(outq_at(0)), 32'h011);
        check("good_b1", 32'(outq_at(1)), 32'h022);
        check("good_b2", 32'(outq_at(2)), 32'h133);
        check("good_err", 32'(err_cnt), 32'd0);
        check("good_idle_valid", 32'(bus.out_valid), 32'd0);

        // Garbage then bad checksum, then a one-byte packet
        clr_mon();
        seq = '{8'h55, 8'h00, 8'hAA, 8'h02, 8'h10, 8'h20, 8'h00};
        send_seq();
        repeat (5) tick();
        check("badchk_err", 32'(err_cnt), 32'd1);
        check("badchk_valid", 32'(vld_cnt), 32'd0);
        clr_mon();
        seq = '{8'hAA, 8'h01, 8'h5A, 8'h5B};
        send_seq();
        repeat (5) tick();
        check("one_count", 32'(outq.size()), 32'd1);
        check("one_b0", 32'(outq_at(0)), 32'h15A);

        // Length limits
        clr_mon();
        seq = '{8'hAA, 8'h00};
        send_seq();
        repeat (2) tick();
        check("len0_err", 32'(err_cnt), 32'd1);
        seq = '{8'hAA, 8'h11};
        send_seq();
        repeat (2) tick();
        check("len17_err", 32'(err_cnt), 32'd2);
        check("len_bad_valid", 32'(vld_cnt), 32'd0);
        clr_mon();
        seq = '{8'hAA, 8'h10};
        for (int i = 1; i <= 16; i++) seq.push_back(8'(i));
        seq.push_back(8'h98);
        send_seq();
        repeat (20) tick();
        check("len16_count", 32'(outq.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("len16_b%0d", i), 32'(outq_at(i)),
                  32'({(i == 15) ? 1'b1 : 1'b0, 8'(i + 1)}));
        end
        check("len16_err", 32'(err_cnt), 32'd0);

        // Checksum wrap, backpressure and a dropped byte
        clr_mon();
        bus.out_ready = 1'b0;
        seq = '{8'hAA, 8'h02, 8'hFF, 8'hFF, 8'h00};
        send_seq();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_valid_%0d", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp_data_%0d", i),  32'(bus.out_data),  32'hFF);
            check($sformatf("bp_last_%0d", i),  32'(bus.out_last),  32'd0);
            tick();
        end
        send_byte(8'hAA);
        repeat (3) tick();
        check("drop_cnt", 32'(drop_cnt), 32'd1);
        check("bp_hold_data", 32'(bus.out_data), 32'hFF);
        bus.out_ready = 1'b1;
        repeat (5) tick();
        check("wrap_count", 32'(outq.size()), 32'd2);
        check("wrap_b0", 32'(outq_at(0)), 32'h0FF);
        check("wrap_b1", 32'(outq_at(1)), 32'h1FF);
        check("wrap_err", 32'(err_cnt), 32'd0);

        // Timeout: error exactly TIMEOUT_CYCLES cycles after the last byte
        clr_mon();
        seq = '{8'hAA, 8'h02, 8'h10};
        send_seq();
        n = 0;
        for (int i = 1; i <= 6000; i++) begin
            tick();
            if (bus.pkt_err) begin
                n = i;
                break;
            end
        end
        check("tmo_cycles", 32'(n), 32'd4350);
        repeat (3) tick();
        check("tmo_err_once", 32'(err_cnt), 32'd1);
        clr_mon();
        seq = '{8'hAA, 8'h01, 8'h7E, 8'h7F};
        send_seq();
        repeat (5) tick();
        check("tmo_next_count", 32'(outq.size()), 32'd1);
        check("tmo_next_b0", 32'(outq_at(0)), 32'h17E);

        // Reset during SEND
        clr_mon();
        bus.out_ready = 1'b0;
        seq = '{8'hAA, 8'h02, 8'h01, 8'h02, 8'h05};
        send_seq();
        check("rs_pre_valid", 32'(bus.out_valid), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        check("rs_valid_now", 32'(bus.out_valid), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) tick();
        check("rs_err", 32'(err_cnt), 32'd0);
        check("rs_none_out", 32'(outq.size()), 32'd0);
        seq = '{8'hAA, 8'h01, 8'h5A, 8'h5B};
        send_seq();
        repeat (5) tick();
        check("rs_next_count", 32'(outq.size()), 32'd1);
        check("rs_next_b0", 32'(outq_at(0)), 32'h15A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
